// File: rtl/bsr_row_walker.sv
// bsr_row_walker: walks BSR row_ptr/col_idx metadata and
// emits one (row, col, block index) task per non-zero block.
module bsr_row_walker #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  cfg_num_block_rows,
  input  logic [IDX_W-1:0]  cfg_num_block_cols,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              meta_rd_en,
  output logic [ADDR_W-1:0] meta_rd_addr,
  output logic [1:0]        meta_rd_type,
  input  logic [31:0]       meta_rd_data,
  input  logic              meta_rd_valid,
  output logic              task_valid,
  input  logic              task_ready,
  output logic [IDX_W-1:0]  task_row,
  output logic [IDX_W-1:0]  task_col,
  output logic [IDX_W-1:0]  task_blk_idx,
  output logic              task_last_in_row,
  output logic [31:0]       perf_tasks,
  output logic [31:0]       perf_stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_PTR0,
    S_WAIT_PTR0,
    S_RD_PTR,
    S_WAIT_PTR,
    S_RD_COL,
    S_WAIT_COL,
    S_EMIT
  } state_t;

  localparam logic [32:0] ADDR_MAX = (33'd1 << ADDR_W) - 33'd1;
  localparam logic [32:0] PTR_MAX  = 33'd1 << ADDR_W;
  localparam logic [1:0]  T_PTR    = 2'b00;
  localparam logic [1:0]  T_COL    = 2'b01;
  localparam logic [1:0]  E_DEC    = 2'b01;
  localparam logic [1:0]  E_OVF    = 2'b10;
  localparam logic [1:0]  E_COL    = 2'b11;

  state_t            state;
  logic [IDX_W-1:0]  n_rows;
  logic [IDX_W-1:0]  n_cols;
  logic [IDX_W-1:0]  r;
  logic [ADDR_W:0]   lo;
  logic [ADDR_W:0]   hi;
  logic [ADDR_W:0]   k;

  logic [32:0]       rd_data_x;
  logic [ADDR_W:0]   rd_ptr;
  logic              ptr_ovf;
  logic              ptr_dec;
  logic              ptr_empty;
  logic              row_last;
  logic              nxt_ovf;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W:0]   k_nxt;
  logic              k_more;
  logic [IDX_W-1:0]  col_val;
  logic              col_bad;

  // Decode of returned data and next-row bookkeeping.
  assign rd_data_x = {1'b0, meta_rd_data};
  assign rd_ptr    = rd_data_x[ADDR_W:0];
  assign ptr_ovf   = rd_data_x > PTR_MAX;
  assign ptr_dec   = rd_ptr < lo;
  assign ptr_empty = rd_ptr == lo;
  assign row_last  = ({1'b0, r} + (IDX_W+1)'(1)) == {1'b0, n_rows};
  assign nxt_ovf   = (33'(r) + 33'd2) > ADDR_MAX;
  assign nxt_addr  = ADDR_W'(33'(r) + 33'd2);
  assign k_nxt     = k + (ADDR_W+1)'(1);
  assign k_more    = k_nxt < hi;
  assign col_val   = meta_rd_data[IDX_W-1:0];
  assign col_bad   = col_val >= n_cols;

  // Walk sequencer with registered read, task and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      n_rows            <= '0;
      n_cols            <= '0;
      r                 <= '0;
      lo                <= '0;
      hi                <= '0;
      k                 <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      err_code          <= 2'b00;
      meta_rd_en        <= 1'b0;
      meta_rd_addr      <= '0;
      meta_rd_type      <= 2'b00;
      task_valid        <= 1'b0;
      task_row          <= '0;
      task_col          <= '0;
      task_blk_idx      <= '0;
      task_last_in_row  <= 1'b0;
      perf_tasks        <= '0;
      perf_stall_cycles <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_rows            <= cfg_num_block_rows;
            n_cols            <= cfg_num_block_cols;
            err               <= 1'b0;
            err_code          <= 2'b00;
            perf_tasks        <= '0;
            perf_stall_cycles <= '0;
            r                 <= '0;
            lo                <= '0;
            hi                <= '0;
            k                 <= '0;
            if (cfg_num_block_rows == '0) begin
              done <= 1'b1;
            end else begin
              busy         <= 1'b1;
              meta_rd_en   <= 1'b1;
              meta_rd_addr <= '0;
              meta_rd_type <= T_PTR;
              state        <= S_RD_PTR0;
            end
          end
        end

        S_RD_PTR0: begin
          meta_rd_en <= 1'b0;
          state      <= S_WAIT_PTR0;
        end

        S_WAIT_PTR0: begin
          if (meta_rd_valid) begin
            if (ptr_ovf) begin
              err      <= 1'b1;
              err_code <= E_OVF;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              lo           <= rd_ptr;
              meta_rd_en   <= 1'b1;
              meta_rd_addr <= ADDR_W'(1);
              meta_rd_type <= T_PTR;
              state        <= S_RD_PTR;
            end
          end
        end

        S_RD_PTR: begin
          meta_rd_en <= 1'b0;
          state      <= S_WAIT_PTR;
        end

        S_WAIT_PTR: begin
          if (meta_rd_valid) begin
            if (ptr_ovf) begin
              err      <= 1'b1;
              err_code <= E_OVF;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (ptr_dec) begin
              err      <= 1'b1;
              err_code <= E_DEC;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (ptr_empty) begin
              hi <= rd_ptr;
              if (row_last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else if (nxt_ovf) begin
                err      <= 1'b1;
                err_code <= E_OVF;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else begin
                r            <= r + IDX_W'(1);
                meta_rd_en   <= 1'b1;
                meta_rd_addr <= nxt_addr;
                meta_rd_type <= T_PTR;
                state        <= S_RD_PTR;
              end
            end else begin
              hi           <= rd_ptr;
              k            <= lo;
              meta_rd_en   <= 1'b1;
              meta_rd_addr <= lo[ADDR_W-1:0];
              meta_rd_type <= T_COL;
              state        <= S_RD_COL;
            end
          end
        end

        S_RD_COL: begin
          meta_rd_en <= 1'b0;
          state      <= S_WAIT_COL;
        end

        S_WAIT_COL: begin
          if (meta_rd_valid) begin
            if (col_bad) begin
              err      <= 1'b1;
              err_code <= E_COL;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              task_valid       <= 1'b1;
              task_row         <= r;
              task_col         <= col_val;
              task_blk_idx     <= IDX_W'(k);
              task_last_in_row <= k_nxt == hi;
              state            <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (task_ready) begin
            task_valid <= 1'b0;
            if (perf_tasks != '1) begin
              perf_tasks <= perf_tasks + 32'd1;
            end
            if (k_more) begin
              k            <= k_nxt;
              meta_rd_en   <= 1'b1;
              meta_rd_addr <= k_nxt[ADDR_W-1:0];
              meta_rd_type <= T_COL;
              state        <= S_RD_COL;
            end else begin
              lo <= hi;
              if (row_last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else if (nxt_ovf) begin
                err      <= 1'b1;
                err_code <= E_OVF;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else begin
                r            <= r + IDX_W'(1);
                meta_rd_en   <= 1'b1;
                meta_rd_addr <= nxt_addr;
                meta_rd_type <= T_PTR;
                state        <= S_RD_PTR;
              end
            end
          end else if (perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bsr_row_walker.md
# bsr_row_walker

Sequencer between the metadata decoder's read port and the systolic-array scheduler. On `start` it walks the BSR structure held in the decoder cache: it reads ROW_PTR entries, then the COL_IDX entries of each block row. It emits one block task per non-zero block as (row, col, block index) over a valid/ready interface. It enforces metadata sanity, reports errors, and counts tasks and back-pressure stalls.

## Interface
- `ADDR_W`, default 8: metadata cache address width; legal indices are 0..2^ADDR_W-1.
- `IDX_W`, default 16: width of the row, column and block-index fields.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins a walk; ignored while `busy`.
- `cfg_num_block_rows` in IDX_W: number of block rows N.
- `cfg_num_block_cols` in IDX_W: number of block columns; bound for column values.
- `busy` out 1: a walk is in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: sticky error flag; cleared on `start`.
- `err_code` out 2: 01 row_ptr decreasing; 10 address overflow; 11 column out of range.
- `meta_rd_en` out 1: one-cycle read request to the decoder.
- `meta_rd_addr` out ADDR_W: read address.
- `meta_rd_type` out 2: 00 ROW_PTR, 01 COL_IDX.
- `meta_rd_data` in 32: read data.
- `meta_rd_valid` in 1: read data valid.
- `task_valid` out 1: a block task is presented.
- `task_ready` in 1: scheduler accepts the task.
- `task_row` out IDX_W: block row of the task.
- `task_col` out IDX_W: block column of the task.
- `task_blk_idx` out IDX_W: block index k of the task.
- `task_last_in_row` out 1: task is the final block of its row.
- `perf_tasks` out 32: number of accepted tasks; cleared on `start`.
- `perf_stall_cycles` out 32: cycles with `task_valid` high and `task_ready` low; cleared on `start`.

## Operation
- States:
  - IDLE
  - RD_PTR0
  - WAIT_PTR0
  - RD_PTR
  - WAIT_PTR
  - RD_COL
  - WAIT_COL
  - EMIT
- Walk algorithm:
  - Read lo = row_ptr[0].
  - For each r in 0..N-1: read hi = row_ptr[r+1]; for k in lo..hi-1, read col_idx[k] and emit (r, col_idx[k][IDX_W-1:0], k); then set lo = hi.
- Empty rows (hi == lo) emit no tasks and go straight to the next row_ptr read.
- Read protocol:
  - `meta_rd_en` is high for exactly one cycle, in the RD_* states.
  - Addr and type are held stable until `meta_rd_valid` returns.
  - At most one read is outstanding at a time.
  - Read latency is unbounded (any value ≥1 cycle).
  - `meta_rd_valid` outside the WAIT_* states is ignored.
- `task_last_in_row` = (k == hi-1).
- Errors (checked when the read returns, before any task is presented):
  - hi < lo gives code 01.
  - r+1 > 2^ADDR_W-1 gives code 10 (N ≥ 256 at defaults). So does k > 2^ADDR_W-1, or a row_ptr value > 2^ADDR_W.
  - col ≥ `cfg_num_block_cols` gives code 11.
  - On any error: set `err` and `err_code`, go to IDLE, drop `busy`, no `done` pulse. The offending task is never presented.
- N == 0: no reads are issued; `done` pulses the cycle after `start`.
- `cfg_*` are sampled into registers on `start`; later changes do not affect the walk in progress.

## Timing
- Reset values:
  - All outputs are 0; the FSM is in IDLE.
  - Counters, `err` and `err_code` are 0.
- `start` sampled at edge T:
  - At T+1: `busy`=1, `meta_rd_en`=1, addr 0, type 00.
  - `err` and the perf counters read 0 from T+1.
- Data returned at edge R issues the next request at R+1; a COL_IDX return presents the task at R+1.
- Task handshake:
  - Task fields are stable while `task_valid` && !`task_ready`.
  - A transfer occurs when both are high at an edge.
  - The next COL_IDX/ROW_PTR request is issued the following cycle.
- Completion:
  - After the final row's last handshake, or after its row_ptr read for an empty row: `done`=1 for one cycle.
  - `busy` falls in that same cycle.
- Counters: `perf_tasks` increments at each handshake edge; `perf_stall_cycles` increments at each stall edge. Both saturate at 2^32-1.
- `rst_n` low at any time asynchronously clears all state. An outstanding read is abandoned and its late `meta_rd_valid` is ignored.

## Test plan
- Memory model for all scenarios: latency 2, `task_ready` high unless stated.
- Basic walk:
  - Stimulus: row_ptr=[0,2,3,3,5], col_idx=[1,3,0,2,4], N=4, cols=8.
  - Response: tasks (0,1,0), (0,3,1), (1,0,2), (3,2,3), (3,4,4).
  - `task_last_in_row` is set on k=1, 2 and 4; row 2 emits nothing.
  - Single `done`; `perf_tasks`=5; `err`=0.
- Back-pressure:
  - Stimulus: same data, `task_ready` low 3 cycles per task.
  - Response: identical sequence with fields stable during stalls, no duplicates; `perf_stall_cycles`=15.
- Empty and ignored cases:
  - N=0 gives `done` at T+1 with no `meta_rd_en`.
  - A second `start` while `busy` has no effect.
- Non-monotonic row_ptr:
  - Stimulus: row_ptr=[0,3,2].
  - Response: row-0 tasks k=0..2 are emitted, then `err`=1, `err_code`=01, no `done`, `busy`=0.
- Column out of range:
  - Stimulus: col_idx[0]=9, cols=8.
  - Response: `err_code`=11; `task_valid` never asserts.
- Reset mid-walk:
  - Stimulus: assert `rst_n` low during WAIT_COL, release, inject a stale `meta_rd_valid`, then `start`.
  - Response: outputs are 0 during reset, the stale data is ignored, and the walk restarts from row_ptr[0] with the correct task sequence.
